// File: rtl/ram_secure_pkg.sv
`default_nettype none
// ============================================================================
// ram_secure_pkg -- shared constants and response-tag type for the RAM arbiter
// Rev 1.0
// ============================================================================
package ram_secure_pkg;

  localparam int RamLatency      = 2;
  localparam int MemAddrBits     = 9;
  localparam int NumPortsDefault = 2;
  localparam int PortIdxBits     = $clog2(NumPortsDefault);

  typedef struct packed {
    logic                   valid;
    logic [PortIdxBits-1:0] idx;
    logic                   err;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/ram_secure_arbiter_if.sv
`default_nettype none
// ============================================================================
// ram_secure_arbiter_if -- requester-side and RAM-side bus of the arbiter
// Rev 1.0
// ============================================================================
interface ram_secure_arbiter_if
  import ram_secure_pkg::*;
#(
  parameter int NumPorts = NumPortsDefault
);

  logic [NumPorts-1:0]    req_i;
  logic [NumPorts-1:0]    we_i;
  logic [4*NumPorts-1:0]  be_i;
  logic [32*NumPorts-1:0] addr_i;
  logic [32*NumPorts-1:0] wdata_i;
  logic [NumPorts-1:0]    gnt_o;
  logic [NumPorts-1:0]    rvalid_o;
  logic [NumPorts-1:0]    err_o;
  logic [32*NumPorts-1:0] rdata_o;

  logic                   ram_req_o;
  logic                   ram_we_o;
  logic [3:0]             ram_be_o;
  logic [31:0]            ram_addr_o;
  logic [31:0]            ram_wdata_o;
  logic                   ram_gnt_i;
  logic                   ram_rvalid_i;
  logic [31:0]            ram_rdata_i;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, err_o, rdata_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_gnt_i, ram_rvalid_i, ram_rdata_i
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, err_o, rdata_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_gnt_i, ram_rvalid_i, ram_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// ram_rr_arbiter -- combinational round-robin pick with a registered pointer
// Rev 1.0
// ============================================================================
module ram_rr_arbiter #(
  parameter  int NumPorts = 2,
  localparam int IdxBits  = $clog2(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req,
  output logic [NumPorts-1:0] gnt,
  output logic [IdxBits-1:0]  idx,
  output logic                valid
);

  logic [IdxBits-1:0] last_q;
  logic [IdxBits-1:0] cand;

  // Search starts one past the previous winner and wraps, so the last winner
  // is considered only after every other port.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NumPorts; off++) begin
      cand = IdxBits'((int'(last_q) + off) % NumPorts);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= IdxBits'(NumPorts - 1);
    end else if (valid) begin
      last_q <= idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_secure_arbiter.sv
`default_nettype none
// ============================================================================
// ram_secure_arbiter -- shares the single-port secure RAM between requesters
// Rev 1.0
// ============================================================================
module ram_secure_arbiter
  import ram_secure_pkg::*;
#(
  parameter int NumPorts    = NumPortsDefault,
  parameter int MemAddrBits = ram_secure_pkg::MemAddrBits,
  parameter int RamLatency  = ram_secure_pkg::RamLatency
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ram_secure_arbiter_if.slave  bus
);

  localparam int IdxBits = $clog2(NumPorts);

  if (NumPorts > (1 << PortIdxBits)) begin : g_idx_width_check
    $error("tag port index too narrow for NumPorts");
  end

  logic [NumPorts-1:0]    req_v;
  logic [NumPorts-1:0]    gnt;
  logic [IdxBits-1:0]     win;
  logic                   any;
  logic                   oor;
  logic                   ram_req;
  logic [31:0]            win_addr;
  tag_t                   tag_q [RamLatency];
  tag_t                   last;
  logic [NumPorts-1:0]    rvalid;
  logic [NumPorts-1:0]    err;
  logic [32*NumPorts-1:0] rdata;

  // Requests are ignored while reset is held so grants read zero in reset.
  assign req_v = bus.req_i & {NumPorts{rst_ni}};

  ram_rr_arbiter #(.NumPorts(NumPorts)) u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req_v),
    .gnt    (gnt),
    .idx    (win),
    .valid  (any)
  );

  assign bus.gnt_o = gnt;

  assign win_addr = bus.addr_i[32*win +: 32];
  assign oor      = |win_addr[31:MemAddrBits];
  assign ram_req  = any & ~oor;

  // Operands reach the RAM only on a real RAM request; otherwise held at zero.
  assign bus.ram_req_o   = ram_req;
  assign bus.ram_we_o    = ram_req & bus.we_i[win];
  assign bus.ram_be_o    = ram_req ? bus.be_i[4*win +: 4]     : 4'h0;
  assign bus.ram_addr_o  = ram_req ? win_addr                 : 32'h0;
  assign bus.ram_wdata_o = ram_req ? bus.wdata_i[32*win +: 32] : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RamLatency; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: any, idx: PortIdxBits'(win), err: any & oor};
      for (int i = 1; i < RamLatency; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign last = tag_q[RamLatency-1];

  always_comb begin
    rvalid = '0;
    err    = '0;
    rdata  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (last.valid && (last.idx == PortIdxBits'(p))) begin
        rvalid[p] = 1'b1;
        err[p]    = last.err;
        if (!last.err) begin
          rdata[32*p +: 32] = bus.ram_rdata_i;
        end
      end
    end
  end

  assign bus.rvalid_o = rvalid;
  assign bus.err_o    = err;
  assign bus.rdata_o  = rdata;

  a_rvalid_matches_tag : assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.ram_rvalid_i == (last.valid && !last.err));

  a_gnt_matches_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.ram_gnt_i == bus.ram_req_o);

endmodule
`default_nettype wire

// File: tb/tb_ram_secure_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_secure_arbiter -- directed vectors against a 2-cycle RAM model
// Rev 1.0
// ============================================================================
module tb_ram_secure_arbiter;

  logic clk_i;
  logic rst_ni;
  int   n_vec;
  int   n_err;

  ram_secure_arbiter_if #(.NumPorts(2)) bus ();

  ram_secure_arbiter #(
    .NumPorts    (2),
    .MemAddrBits (9),
    .RamLatency  (2)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // RAM model: 128 words, two-stage read pipeline, writes ack with zero data.
  logic [31:0] mem [128];
  logic        v1, v2;
  logic [31:0] d1, d2;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= 32'h0;
      d2 <= 32'h0;
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
      mem[2] <= 32'hCAFEF00D;
    end else begin
      v1 <= bus.ram_req_o;
      d1 <= (bus.ram_req_o && !bus.ram_we_o) ? mem[bus.ram_addr_o[8:2]] : 32'h0;
      if (bus.ram_req_o && bus.ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_be_o[b]) mem[bus.ram_addr_o[8:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
        end
      end
      v2 <= v1;
      d2 <= d1;
    end
  end

  assign bus.ram_rvalid_i = v2;
  assign bus.ram_rdata_i  = d2;
  assign bus.ram_gnt_i    = bus.ram_req_o;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_i[p]           = r;
    bus.we_i[p]            = w;
    bus.be_i[4*p +: 4]     = be;
    bus.addr_i[32*p +: 32] = a;
    bus.wdata_i[32*p +: 32] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic check_ram_idle(input string tag);
    check({tag, "_ctrl"}, 64'({bus.ram_req_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o}), 64'h0);
    check({tag, "_wdata"}, 64'(bus.ram_wdata_o), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_ni      = 1'b0;
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;

    // Reset state
    sample();
    check("rst_gnt", 64'(bus.gnt_o), 64'h0);
    check("rst_rvalid", 64'({bus.rvalid_o, bus.err_o}), 64'h0);
    check("rst_rdata", 64'(bus.rdata_o), 64'h0);
    check_ram_idle("rst_ram");
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;

    // Single read on port 0
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    sample();
    check("rd_gnt", 64'(bus.gnt_o), 64'h1);
    check("rd_ram_addr", 64'({bus.ram_req_o, bus.ram_addr_o}), 64'h1_0000_0010);
    next_cycle();
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    check("rd_rvalid_t1", 64'(bus.rvalid_o), 64'h0);
    next_cycle();
    sample();
    check("rd_rvalid_t2", 64'({bus.rvalid_o, bus.err_o}), 64'h4);
    check("rd_rdata", 64'(bus.rdata_o), 64'h0000_0000_DEAD_BEEF);

    // Byte write then read on port 1
    next_cycle();
    drive(1, 1'b1, 1'b1, 4'b0101, 32'h24, 32'hAABBCCDD);
    sample();
    check("wr_gnt", 64'(bus.gnt_o), 64'h2);
    check("wr_ram_ops", 64'({bus.ram_we_o, bus.ram_be_o, bus.ram_wdata_o}), 64'h15_AABB_CCDD);
    next_cycle();
    drive(1, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
    sample();
    check("wr_rd_gnt", 64'(bus.gnt_o), 64'h2);
    next_cycle();
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    check("wr_ack", 64'({bus.rvalid_o, bus.err_o}), 64'h8);
    check("wr_ack_data", 64'(bus.rdata_o), 64'h0);
    next_cycle();
    sample();
    check("wr_rd_rvalid", 64'(bus.rvalid_o), 64'h2);
    check("wr_rd_data", 64'(bus.rdata_o), 64'h00BB_00DD_0000_0000);

    // Out-of-range access on port 1
    next_cycle();
    drive(1, 1'b1, 1'b1, 4'hF, 32'h200, 32'h55);
    sample();
    check("oor_gnt", 64'(bus.gnt_o), 64'h2);
    check_ram_idle("oor_ram");
    next_cycle();
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    check("oor_rvalid_t1", 64'(bus.rvalid_o), 64'h0);
    next_cycle();
    sample();
    check("oor_resp", 64'({bus.rvalid_o, bus.err_o}), 64'hA);
    check("oor_rdata", 64'(bus.rdata_o), 64'h0);

    // Idle masking with noisy idle operands
    next_cycle();
    drive(0, 1'b0, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      sample();
      check($sformatf("idle_gnt_c%0d", k), 64'(bus.gnt_o), 64'h0);
      check_ram_idle($sformatf("idle_ram_c%0d", k));
      next_cycle();
    end

    // Reset one cycle after a grant
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    sample();
    check("mid_gnt", 64'(bus.gnt_o), 64'h1);
    next_cycle();
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_ni = 1'b0;
    sample();
    check("mid_rvalid_t1", 64'(bus.rvalid_o), 64'h0);
    next_cycle();
    sample();
    check("mid_rvalid_t2", 64'(bus.rvalid_o), 64'h0);
    next_cycle();
    rst_ni = 1'b1;

    // Contention: both ports request for 6 cycles, then drain
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 4'hF, 32'h08, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 6) begin
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      sample();
      if (k < 6) check($sformatf("cont_gnt_c%0d", k), 64'(bus.gnt_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      else       check($sformatf("cont_gnt_c%0d", k), 64'(bus.gnt_o), 64'h0);
      if (k >= 2) begin
        check($sformatf("cont_rvalid_c%0d", k), 64'(bus.rvalid_o), (k % 2 == 0) ? 64'h1 : 64'h2);
        check($sformatf("cont_rdata_c%0d", k), 64'(bus.rdata_o),
              (k % 2 == 0) ? 64'h0000_0000_DEAD_BEEF : 64'hCAFE_F00D_0000_0000);
      end else begin
        check($sformatf("cont_rvalid_c%0d", k), 64'(bus.rvalid_o), 64'h0);
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_secure_arbiter.md
# ram_secure_arbiter

Round-robin arbiter that shares the single-port secure RAM between `NumPorts` requesters, e.g. the core's instruction fetch port (port 0) and its LSU data port (port 1). It sits between the requesters and the RAM. It forwards at most one request per cycle, with a grant in the same cycle. It routes each fixed-latency response back to the port that issued it. It masks idle and foreign datapath values to zero so that no unselected operand toggles the RAM inputs or another port's read bus. Addresses outside the RAM are answered locally with an error and the same latency, so response timing is independent of address validity.

## Interface
- `NumPorts`, 2: number of requesters, ≥2.
- `MemAddrBits`, 9: byte-address bits covered by the RAM; 512 B matches the RAM's default of 16 blocks × 8 words.
- `RamLatency`, 2: fixed cycles from RAM request to RAM `rvalid`; must equal the RAM's pipeline depth.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, NumPorts: per-port request.
- `we_i`, in, NumPorts: per-port write enable.
- `be_i`, in, 4·NumPorts: per-port byte enables.
- `addr_i`, in, 32·NumPorts: per-port byte address.
- `wdata_i`, in, 32·NumPorts: per-port write data.
- `gnt_o`, out, NumPorts: per-port grant; combinational; one-hot or zero.
- `rvalid_o`, out, NumPorts: per-port response valid; one-hot or zero.
- `err_o`, out, NumPorts: per-port response error; qualified by `rvalid_o`.
- `rdata_o`, out, 32·NumPorts: per-port read data.
- `ram_req_o`, `ram_we_o`, out, 1 each: to RAM.
- `ram_be_o` (4), `ram_addr_o` (32), `ram_wdata_o` (32), out: to RAM.
- `ram_gnt_i`, in, 1: from RAM; always equals `ram_req_o`, unused except in the assertion below.
- `ram_rvalid_i`, in, 1: from RAM.
- `ram_rdata_i`, in, 32: from RAM.

## Operation
- **Selection:** among asserted `req_i`, the winner is the first index strictly after `last_q`, searching cyclically. `gnt_o[winner]=1` in the same cycle; all other grants are 0.
- **Priority pointer:** `last_q` resets to NumPorts−1, so port 0 wins first. It updates to the winner only on a cycle with a grant and holds otherwise.
- **Hold rule:** losing requesters must hold their request and operands stable until granted. No queueing is done in this block.
- **Range check:** an address is in range when `addr_i[31:MemAddrBits]==0`.
  - In-range winner: `ram_req_o=1`; we, be, addr and wdata are taken from the winner.
  - Out-of-range winner: still granted, but `ram_req_o=0`.
- **Idle masking:** while `ram_req_o=0`, all `ram_*` outputs are 0.
- **Tag pipeline:** `RamLatency` stages, each holding {valid, port index, err}. Stage 0 loads {grant-any, winner, out-of-range} every cycle. Later stages shift unconditionally.
- **Response:** from the last stage, when valid, `rvalid_o[port]=1` and `err_o[port]=err`.
  - `rdata_o[port]` is `ram_rdata_i` when err=0, and 0 when err=1.
  - All non-addressed `rdata_o` lanes are 0 at all times.
- **Writes:** the RAM also raises rvalid for writes, with zero data. The response is forwarded unchanged, as the write acknowledge.
- **Assertions:** `ram_rvalid_i` equals the last-stage valid ∧ ¬err. `ram_gnt_i` equals `ram_req_o`.

## Timing
- A request granted in cycle t produces its response on that port in cycle t+RamLatency, i.e. t+2 at default.
- Throughput is one grant per cycle. Back-to-back grants, to the same or alternating ports, respond back-to-back in grant order.
- **Simultaneous requests:** one grant per cycle, round-robin. With both ports requesting continuously, grants alternate 0,1,0,1…
- **Wrap-around:** the search after index NumPorts−1 wraps to 0.
- **Errors:** error responses take exactly the same cycle as a RAM response would, which keeps timing constant.
- **Reset values:** `gnt_o`, `rvalid_o`, `err_o`, `rdata_o` and `ram_*` outputs are 0; tag valids are 0; `last_q`=NumPorts−1.
- **Reset mid-operation:** in-flight tags are cleared, so no response is delivered for requests granted before reset. The RAM clears its own rvalid on the same reset.

## Structure
- **Package `ram_secure_pkg`:** `RamLatency`, `MemAddrBits`, `NumPortsDefault`, and the tag struct type {valid, port idx [$clog2(NumPorts)], err}.
- **Sub-module `ram_rr_arbiter`:** `req` vector in, one-hot `gnt` and encoded index out, internal `last_q`. The parent holds the operand mux, range check, masking and tag pipeline.

## Test plan
- **Single read:** after reset, port 0 reads 0x10 holding 0xDEADBEEF.
  - Response: `gnt_o=01` at t, `rvalid_o=01` at t+2, `rdata_o[0]`=0xDEADBEEF, `rdata_o[1]`=0.
- **Contention:** both ports request every cycle for 6 cycles.
  - Response: grants 01,10,01,10,01,10; rvalids follow 2 cycles later in the same order, with the correct per-port data.
- **Byte write then read:** port 1 writes 0xAABBCCDD to 0x24 with be=0101, then reads 0x24 over an old value of 0.
  - Response: the write ack has rvalid at t+2 with data 0; the read returns 0x00BB00DD.
- **Out-of-range:** port 1 accesses 0x200.
  - Response: `gnt_o[1]=1` and `ram_req_o=0` at t; all `ram_*` outputs are 0; at t+2, `rvalid_o[1]=1`, `err_o[1]=1`, `rdata_o[1]`=0.
- **Idle masking:** port 0 idles with addr=0xFFFFFFFF and wdata=0x12345678.
  - Response: all `ram_*` outputs remain 0 for every idle cycle.
- **Reset mid-flight:** assert `rst_ni` low one cycle after a grant.
  - Response: no rvalid ever appears for that grant; after release, the first grant goes to port 0 when both ports request.
